// File: rtl/bch_stream_if.sv
// bch_stream_if: bit-serial valid/ready message input and codeword output of the BCH encoder.
interface bch_stream_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_last;
  logic out_ready;
  logic busy;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bch_stream_encoder.sv
// bch_stream_encoder: systematic BCH(N,K) encoder; message bits pass through while an LFSR
// divides by g(x), then the N-K parity bits are shifted out, all behind one output register.
module bch_stream_encoder #(
  parameter int N = 15,
  parameter int K = 7,
  parameter logic [N-K:0] GEN_POLY = 9'b111010001
) (
  input  logic        clk,
  input  logic        rst_n,
  bch_stream_if.slave s
);
  localparam int M = N - K;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] P_LAST = CW'(M - 1);
  localparam logic [M-1:0] TAPS = GEN_POLY[M-1:0];
  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;
  state_t state_q, state_d;
  logic [M-1:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic out_data_q, out_data_d;
  logic out_last_q, out_last_d;
  logic adv, xfer;
  assign adv = !out_valid_q || s.out_ready;
  assign s.in_ready = adv && state_q != PAR;
  assign xfer = s.in_valid && s.in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data = out_data_q;
  assign s.out_last = out_last_q;
  assign s.busy = state_q != IDLE || out_valid_q;
  // IDLE has cnt==0, so K==1 falls out of the same cnt==K-1 test as MSG
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    cnt_d = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (xfer) begin
      r_d = (r_q << 1) ^ ((s.in_data ^ r_q[M-1]) ? TAPS : '0);
      out_valid_d = 1'b1;
      out_data_d = s.in_data;
      out_last_d = 1'b0;
      state_d = cnt_q == K_LAST ? PAR : MSG;
      cnt_d = cnt_q == K_LAST ? '0 : cnt_q + 1'b1;
    end else if (adv && state_q == PAR) begin
      r_d = r_q << 1;
      out_valid_d = 1'b1;
      out_data_d = r_q[M-1];
      out_last_d = cnt_q == P_LAST;
      state_d = cnt_q == P_LAST ? IDLE : PAR;
      cnt_d = cnt_q == P_LAST ? '0 : cnt_q + 1'b1;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end
endmodule

// File: tb/tb_bch_stream_encoder.sv
// tb_bch_stream_encoder: table vectors, stalled/random frames vs a long-division model,
// back-to-back, mid-frame reset and a BCH(7,4) instance.
module tb_bch_stream_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bch_stream_if ifa ();
  bch_stream_if ifb ();
  bch_stream_encoder dut_a (.clk(clk), .rst_n(rst_n), .s(ifa.slave));
  bch_stream_encoder #(.N(7), .K(4), .GEN_POLY(4'b1011)) dut_b (.clk(clk), .rst_n(rst_n), .s(ifb.slave));
  typedef struct {
    bit          sel;
    logic [14:0] msg;
    logic [14:0] cw;
  } vec_t;
  vec_t vt[5];
  int checks = 0;
  int errors = 0;
  logic [14:0] cw_got;
  int last_pos, irlow, gaps, idle_cyc;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask
  // remainder of msg(x)*x^(n-k) divided by g(x) by polynomial long division
  function automatic logic [14:0] encode(input int n, input int k, input logic [15:0] g, input logic [14:0] msg);
    logic [31:0] a;
    a = 32'(msg) << (n - k);
    for (int i = n - 1; i >= n - k; i--)
      if (a[i]) a = a ^ (32'(g) << (i - (n - k)));
    return 15'((32'(msg) << (n - k)) | a);
  endfunction
  task automatic step(input bit sel, input logic iv, input logic id, input logic orr,
                      output logic ir, output logic ov, output logic od, output logic ol, output logic bz);
    @(negedge clk);
    if (sel) begin
      ifb.in_valid = iv; ifb.in_data = id; ifb.out_ready = orr;
    end else begin
      ifa.in_valid = iv; ifa.in_data = id; ifa.out_ready = orr;
    end
    #1;
    ir = sel ? ifb.in_ready : ifa.in_ready;
    ov = sel ? ifb.out_valid : ifa.out_valid;
    od = sel ? ifb.out_data : ifa.out_data;
    ol = sel ? ifb.out_last : ifa.out_last;
    bz = sel ? ifb.busy : ifa.busy;
  endtask
  task automatic run(input bit sel, input int nf, input logic [14:0] m0, input logic [14:0] m1,
                     input int bp, input int gap, input int abort, input string nm);
    int n, k, sent, got, cyc;
    logic [14:0] msg[2];
    logic [14:0] exp[2];
    logic pov, por, pod, pol, ir, ov, od, ol, bz, iv, id, orr;
    bit started;
    n = sel ? 7 : 15;
    k = sel ? 4 : 7;
    msg[0] = m0; msg[1] = m1;
    for (int f = 0; f < 2; f++) exp[f] = encode(n, k, sel ? 16'b1011 : 16'b111010001, msg[f]);
    sent = 0; got = 0; cyc = 0; pov = 0; por = 1; pod = 0; pol = 0; started = 0;
    cw_got = '0; last_pos = -1; irlow = 0; gaps = 0; idle_cyc = 0;
    while (got < nf * n && cyc < 2000 && !(abort > 0 && got >= abort)) begin
      iv = sent < nf * k && $urandom_range(99) >= gap;
      id = iv ? msg[sent / k][k - 1 - sent % k] : 1'b0;
      orr = $urandom_range(99) >= bp;
      step(sel, iv, id, orr, ir, ov, od, ol, bz);
      if (pov && !por) chk({nm, "_hold"}, {29'd0, ov, od, ol}, {29'd0, 1'b1, pod, pol});
      if (iv && ir) sent++;
      if (ov && orr) begin
        chk({nm, "_bit"}, {31'd0, od}, {31'd0, exp[got / n][n - 1 - got % n]});
        chk({nm, "_last"}, {31'd0, ol}, {31'd0, got % n == n - 1});
        if (got < n) cw_got[n - 1 - got] = od;
        if (ol && last_pos < 0) last_pos = got;
        got++;
      end
      started |= ov;
      if (started && got < nf * n) begin
        if (!ov) gaps++;
        if (!bz) idle_cyc++;
      end
      if (!ir) irlow++;
      pov = ov; por = orr; pod = od; pol = ol;
      cyc++;
    end
    if (cyc >= 2000) chk({nm, "_timeout"}, 32'(got), 32'(nf * n));
    @(negedge clk);
    if (sel) begin ifb.in_valid = 0; ifb.out_ready = 1; end
    else begin ifa.in_valid = 0; ifa.out_ready = 1; end
  endtask
  initial begin
    ifa.in_valid = 0; ifa.in_data = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_data = 0; ifb.out_ready = 1;
    vt[0] = '{0, 15'b0000001, 15'b000000111010001};
    vt[1] = '{0, 15'b1000000, 15'b100000011101000};
    vt[2] = '{0, 15'b1111111, 15'b111111111111111};
    vt[3] = '{0, 15'b0000000, 15'b000000000000000};
    vt[4] = '{1, 15'b1000, 15'b1000101};
    #12;
    chk("rst_a", {27'd0, ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_last, ifa.busy}, 32'b10000);
    chk("rst_b", {27'd0, ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.out_last, ifb.busy}, 32'b10000);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      run(vt[i].sel, 1, vt[i].msg, 0, 0, 0, 0, "vec");
      chk($sformatf("vec%0d_cw", i), 32'(cw_got), 32'(vt[i].cw));
      chk($sformatf("vec%0d_lastpos", i), 32'(last_pos), vt[i].sel ? 32'd6 : 32'd14);
      chk($sformatf("vec%0d_irlow", i), 32'(irlow), vt[i].sel ? 32'd3 : 32'd8);
    end
    run(0, 1, 15'b1111111, 0, 50, 30, 0, "stall");
    chk("stall_cw", 32'(cw_got), 32'h7fff);
    run(0, 2, 15'b0000000, 15'b0000001, 0, 0, 0, "b2b");
    chk("b2b_gaps", 32'(gaps), 0);
    chk("b2b_busy", 32'(idle_cyc), 0);
    run(0, 1, 15'b1111111, 0, 0, 0, 10, "abort");
    #2 rst_n = 0;
    #1 chk("midrst", {27'd0, ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_last, ifa.busy}, 32'b10000);
    @(negedge clk) rst_n = 1;
    run(0, 1, 15'b0000001, 0, 0, 0, 0, "post_rst");
    chk("post_rst_cw", 32'(cw_got), 32'b000000111010001);
    for (int i = 0; i < 4; i++)
      run(i[0], 2, 15'($urandom), 15'($urandom), 30, 20, 0, "rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
